tdp18k_port_arb: RTL
====================

# tdp18k_port_arb

Two-requester round-robin arbiter that shares port A of one TDP18K_FIFO instance operated as plain RAM (FMODE_i=0, RMODE_A_i=WMODE_A_i=MODE_18). It grants at most one 18-bit access per cycle, routes returning read data back to the issuing requester, and runs a built-in clear sweep that zeroes all 1024 words. It sits between the user-logic requesters and the RAM macro wrapper. Port B is outside this block.

## Interface
- WAW, 10, word address width (1024 x 18 words).
- DW, 18, data width.
- CLK_i  in  1  single clock; drives CLK_A_i of the RAM.
- RST_ni  in  1  reset, asynchronous, active-low.
- REQ_0_i / REQ_1_i  in  1  access request, level, held until granted.
- WE_0_i / WE_1_i  in  1  1=write, 0=read; valid with REQ.
- ADDR_0_i / ADDR_1_i  in  WAW  word address.
- WDATA_0_i / WDATA_1_i  in  DW  write data.
- BE_0_i / BE_1_i  in  2  byte enables: [1] covers bits {17,15:8}, [0] covers bits {16,7:0}.
- GNT_0_o / GNT_1_o  out  1  combinational grant; request accepted in this cycle.
- RVALID_0_o / RVALID_1_o  out  1  RDATA_o is valid for this requester.
- RDATA_o  out  DW  read data, equal to RAM_RDATA_i.
- CLR_i  in  1  single-cycle pulse that starts the clear sweep.
- BUSY_o  out  1  clear sweep in progress.
- CLR_DONE_o  out  1  one-cycle pulse when the sweep completes.
- RAM_WEN_o, RAM_REN_o  out  1  drive WEN_A_i and REN_A_i.
- RAM_ADDR_o  out  14  drives ADDR_A_i as {word_addr, 4'b0000}.
- RAM_WDATA_o  out  DW  drives WDATA_A_i.
- RAM_BE_o  out  2  drives BE_A_i.
- RAM_RDATA_i  in  DW  from RDATA_A_o.

## Operation
- FSM states are RUN and CLEAR. Reset state is RUN.
- Transitions:
  - RUN -> CLEAR when CLR_i=1.
  - CLEAR -> RUN after the write to word 1023.
  - CLR_i is ignored while in CLEAR.
- Arbitration in RUN:
  - Priority pointer `prio` is 1 bit, reset value 0.
  - If only one REQ is high, that requester is granted.
  - If both REQs are high, requester `prio` is granted.
  - After any grant, `prio` becomes the complement of the granted index.
  - A lone requester holding REQ high is granted every cycle.
- A granted cycle drives the RAM combinationally from the winner:
  - Write (WE=1): RAM_WEN_o=1, RAM_REN_o=0, RAM_ADDR_o={ADDR,4'b0}, RAM_WDATA_o=WDATA, RAM_BE_o=BE.
  - Read (WE=0): RAM_REN_o=1, RAM_WEN_o=0, RAM_BE_o=2'b00, RAM_WDATA_o=0.
- With no grant, RAM_WEN_o=RAM_REN_o=0, RAM_ADDR_o=0, RAM_WDATA_o=0, RAM_BE_o=0.
- Read return:
  - A registered flag `rd_pend` plus `rd_id` capture a granted read.
  - The next cycle, RVALID_{rd_id}_o=1 for exactly one cycle.
- In CLEAR:
  - No GNT is issued; REQs stay pending and `prio` is frozen.
  - Counter `clr_addr` (WAW bits) runs 0..1023, one word per cycle.
  - Each cycle drives RAM_WEN_o=1, RAM_WDATA_o=0, RAM_BE_o=2'b11.
  - CLR_DONE_o pulses the cycle after the write to word 1023, and `clr_addr` wraps to 0.
- Entering CLEAR does not cancel a read granted in the preceding cycle; its RVALID still fires.
- No read/write forwarding: a read issued the cycle after a write to the same address returns whatever the RAM returns.

## Timing
- Reset values: GNT_*=0, RVALID_*=0, BUSY_o=0, CLR_DONE_o=0, all RAM_* outputs 0, prio=0, rd_pend=0, clr_addr=0.
- Grant latency is 0 cycles (same cycle as REQ). Throughput is 1 access per cycle in total.
- Read latency: grant in cycle N gives RVALID in cycle N+1. RDATA_o = RAM_RDATA_i in that cycle, matching the 1-cycle synchronous RAM read.
- CLR_i sampled in cycle N:
  - BUSY_o=1 from N+1 through N+1024.
  - Clear writes occur in cycles N+1..N+1024.
  - CLR_DONE_o=1 and BUSY_o=0 in cycle N+1025; grants resume the same cycle.
- CLR_i in the same cycle as REQs: that cycle still arbitrates normally; CLEAR starts next cycle.
- RST_ni asserted mid-sweep: all state returns to reset values immediately, the sweep is abandoned, and no CLR_DONE_o pulse is produced.
- RST_ni asserted with a read pending: RVALID is suppressed.

## Test plan
- Reset then REQ_0 read of address 5, with word 5 preloaded to 18'h2A5A5 -> GNT_0 in the same cycle; RAM_ADDR_o=14'h0050; the next cycle RVALID_0=1 and RDATA_o=18'h2A5A5.
- Both requesters hold REQ for 4 cycles -> grants alternate 0,1,0,1 and each requester sees exactly 2 grants.
- REQ_1 write 18'h3FFFF to address 7 with BE=2'b01, then read address 7 -> RDATA_o=18'h100FF (prior contents 0).
- CLR_i pulse with REQ_0 held -> BUSY_o high for 1024 cycles, no GNT_0, CLR_DONE_o pulses once, then GNT_0 in that same cycle; reading all addresses returns 0.
- RST_ni low at sweep cycle 300 -> BUSY_o=0 immediately, no CLR_DONE_o, and prio=0 after release.
- Read granted in the cycle of CLR_i -> RVALID is still delivered in the next cycle while BUSY_o=1.

Source files
------------

// File: rtl/tdp18k_port_arb.sv
// Round-robin arbiter sharing port A of a TDP18K RAM between two requesters,
// with read-return steering and a built-in zeroing sweep of all words.
module tdp18k_port_arb #(
  parameter int WAW = 10,
  parameter int DW  = 18
) (
  input  logic             CLK_i,
  input  logic             RST_ni,
  input  logic             REQ_0_i,
  input  logic             REQ_1_i,
  input  logic             WE_0_i,
  input  logic             WE_1_i,
  input  logic [WAW-1:0]   ADDR_0_i,
  input  logic [WAW-1:0]   ADDR_1_i,
  input  logic [DW-1:0]    WDATA_0_i,
  input  logic [DW-1:0]    WDATA_1_i,
  input  logic [1:0]       BE_0_i,
  input  logic [1:0]       BE_1_i,
  output logic             GNT_0_o,
  output logic             GNT_1_o,
  output logic             RVALID_0_o,
  output logic             RVALID_1_o,
  output logic [DW-1:0]    RDATA_o,
  input  logic             CLR_i,
  output logic             BUSY_o,
  output logic             CLR_DONE_o,
  output logic             RAM_WEN_o,
  output logic             RAM_REN_o,
  output logic [WAW+3:0]   RAM_ADDR_o,
  output logic [DW-1:0]    RAM_WDATA_o,
  output logic [1:0]       RAM_BE_o,
  input  logic [DW-1:0]    RAM_RDATA_i,
  output logic             DBG_STATE_o,
  output logic             DBG_PRIO_o
);

  // Handshake: REQ_x_i is a level held until GNT_x_o is seen high in the same
  // cycle; a granted read returns one cycle later as RVALID_x_o with RDATA_o.

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic           prio_q, prio_d;
  logic           rd_pend_q, rd_pend_d;
  logic           rd_id_q, rd_id_d;
  logic [WAW-1:0] clr_addr_q, clr_addr_d;
  logic           clr_done_q, clr_done_d;

  logic           gnt_0, gnt_1, win;
  logic           win_we;
  logic [WAW-1:0] win_addr;
  logic [DW-1:0]  win_wdata;
  logic [1:0]     win_be;

  always_ff @(posedge CLK_i or negedge RST_ni) begin
    if (!RST_ni) begin
      state_q    <= ST_RUN;
      prio_q     <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_id_q    <= 1'b0;
      clr_addr_q <= '0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      rd_pend_q  <= rd_pend_d;
      rd_id_q    <= rd_id_d;
      clr_addr_q <= clr_addr_d;
      clr_done_q <= clr_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    rd_pend_d   = 1'b0;
    rd_id_d     = rd_id_q;
    clr_addr_d  = clr_addr_q;
    clr_done_d  = 1'b0;
    gnt_0       = 1'b0;
    gnt_1       = 1'b0;
    win         = 1'b0;
    win_we      = 1'b0;
    win_addr    = '0;
    win_wdata   = '0;
    win_be      = 2'b00;
    RAM_WEN_o   = 1'b0;
    RAM_REN_o   = 1'b0;
    RAM_ADDR_o  = '0;
    RAM_WDATA_o = '0;
    RAM_BE_o    = 2'b00;

    case (state_q)
      ST_RUN: begin
        if (REQ_0_i && (!REQ_1_i || !prio_q)) begin
          gnt_0 = 1'b1;
        end else if (REQ_1_i) begin
          gnt_1 = 1'b1;
        end
        win       = gnt_1;
        win_we    = win ? WE_1_i    : WE_0_i;
        win_addr  = win ? ADDR_1_i  : ADDR_0_i;
        win_wdata = win ? WDATA_1_i : WDATA_0_i;
        win_be    = win ? BE_1_i    : BE_0_i;
        if (gnt_0 || gnt_1) begin
          prio_d     = ~win;
          RAM_ADDR_o = {win_addr, 4'b0000};
          if (win_we) begin
            RAM_WEN_o   = 1'b1;
            RAM_WDATA_o = win_wdata;
            RAM_BE_o    = win_be;
          end else begin
            RAM_REN_o = 1'b1;
            rd_pend_d = 1'b1;
            rd_id_d   = win;
          end
        end
        if (CLR_i) begin
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        RAM_WEN_o  = 1'b1;
        RAM_ADDR_o = {clr_addr_q, 4'b0000};
        RAM_BE_o   = 2'b11;
        // Counter wraps back to 0 naturally after the last word.
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == '1) begin
          state_d    = ST_RUN;
          clr_done_d = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign GNT_0_o     = gnt_0;
  assign GNT_1_o     = gnt_1;
  assign RVALID_0_o  = rd_pend_q && !rd_id_q;
  assign RVALID_1_o  = rd_pend_q &&  rd_id_q;
  assign RDATA_o     = RAM_RDATA_i;
  assign BUSY_o      = (state_q == ST_CLEAR);
  assign CLR_DONE_o  = clr_done_q;
  assign DBG_STATE_o = state_q;
  assign DBG_PRIO_o  = prio_q;

endmodule
